// File: rtl/rhythm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rhythm_pkg
//  Purpose  : Shared types and constants for the falling-arrow note scheduler:
//             game state encoding, control/lane keycodes and chart word fields.
//  Revision : 1.0  initial release
// ============================================================================
package rhythm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } game_state_t;

   localparam logic [7:0] KEY_START   = 8'h2c;
   localparam logic [7:0] KEY_RESTART = 8'h01;

   localparam int NUM_LANES = 4;

   localparam logic [7:0] KEY_LEFT  = 8'h50;
   localparam logic [7:0] KEY_DOWN  = 8'h51;
   localparam logic [7:0] KEY_UP    = 8'h52;
   localparam logic [7:0] KEY_RIGHT = 8'h4f;

   // Indexed by lane number: lane0=left, lane1=down, lane2=up, lane3=right
   localparam logic [NUM_LANES-1:0][7:0] LANE_KEY = {KEY_RIGHT, KEY_UP, KEY_DOWN, KEY_LEFT};

   // Chart word layout: [15]=last entry, [14:13]=lane, [12:0]=launch frame
   localparam int CH_LAST_BIT = 15;
   localparam int CH_LANE_HI  = 14;
   localparam int CH_LANE_LO  = 13;
   localparam int CH_FRAME_HI = 12;
   localparam int CH_FRAME_LO = 0;

endpackage
`default_nettype wire

// File: rtl/note_slot_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : note_slot_alloc
//  Purpose  : Lowest-index free slot priority encoder for arrow launches.
//  Revision : 1.0  initial release
// ============================================================================
module note_slot_alloc
   import rhythm_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int IDX_W     = 3
)(
   input  logic [NUM_SLOTS-1:0] free_mask,
   output logic [IDX_W-1:0]     free_idx,
   output logic                 free_found
);

   // Scan from the top down so the lowest free index is the last one written
   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free_mask[i]) begin
            free_idx   = IDX_W'(i);
            free_found = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/note_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : note_scheduler
//  Purpose  : Chart-driven arrow sequencer. Fetches timed notes from a chart
//             ROM, launches them into free slots, moves arrows once per frame,
//             judges hits/misses from two keycodes and keeps score/combo.
//  Revision : 1.0  initial release
// ============================================================================
module note_scheduler
   import rhythm_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int CHART_AW  = 8,
   parameter int Y_START   = 100,
   parameter int Y_MAX     = 400,
   parameter int HIT_LO    = 340,
   parameter int ARROW_H   = 40
)(
   input  logic                     frame_clk,
   input  logic                     Reset,
   input  logic [7:0]               keycode,
   input  logic [7:0]               keycode_second,
   output logic [CHART_AW-1:0]      chart_addr,
   input  logic [15:0]              chart_data,
   output logic [NUM_SLOTS-1:0]     slot_active,
   output logic [2*NUM_SLOTS-1:0]   slot_lane,
   output logic [10*NUM_SLOTS-1:0]  slot_y,
   output logic [15:0]              score,
   output logic [7:0]               combo,
   output logic                     hit_pulse,
   output logic                     miss_pulse,
   output logic [1:0]               game_state
);

   localparam int         IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [9:0] Y_START_V = 10'(Y_START);
   // Window limits re-expressed on the top edge so no adder is needed per compare
   localparam logic [9:0] MISS_Y    = 10'(Y_MAX - ARROW_H);
   localparam logic [9:0] HIT_Y     = 10'(HIT_LO - ARROW_H);

   game_state_t                  state_q, state_d;
   logic [12:0]                  frame_cnt_q, frame_cnt_d;
   logic [CHART_AW-1:0]          chart_addr_q, chart_addr_d;
   logic [15:0]                  pending_q, pending_d;
   logic                         pending_valid_q, pending_valid_d;
   logic                         refill_q, refill_d;
   logic                         chart_done_q, chart_done_d;
   logic [NUM_SLOTS-1:0]         active_q, active_d;
   logic [NUM_SLOTS-1:0][1:0]    lane_q, lane_d;
   logic [NUM_SLOTS-1:0][9:0]    y_q, y_d;
   logic [15:0]                  score_q, score_d;
   logic [7:0]                   combo_q, combo_d;
   logic                         hit_q, hit_d;
   logic                         miss_q, miss_d;
   logic [NUM_LANES-1:0]         press_prev_q, press_prev_d;
   logic [NUM_LANES-1:0]         pressed_now;
   logic [NUM_LANES-1:0]         press_edge;
   logic [NUM_SLOTS-1:0]         free_mask;
   logic [IDX_W-1:0]             free_idx;
   logic                         free_found;

   // Slots freed during this frame stay unavailable until the next one
   assign free_mask = ~active_q;

   note_slot_alloc #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) u_alloc (
      .free_mask  (free_mask),
      .free_idx   (free_idx),
      .free_found (free_found)
   );

   // A lane is held when either keycode matches its key
   always_comb begin
      pressed_now = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         pressed_now[l] = (keycode == LANE_KEY[l]) || (keycode_second == LANE_KEY[l]);
      end
   end

   assign press_edge = pressed_now & ~press_prev_q;

   // Game sequencing: next state, slot movement, judging and launching
   always_comb begin
      logic       found;
      int         best;
      logic [9:0] best_y;

      found           = 1'b0;
      best            = 0;
      best_y          = '0;
      state_d         = state_q;
      frame_cnt_d     = frame_cnt_q;
      chart_addr_d    = chart_addr_q;
      pending_d       = pending_q;
      pending_valid_d = pending_valid_q;
      refill_d        = refill_q;
      chart_done_d    = chart_done_q;
      active_d        = active_q;
      lane_d          = lane_q;
      y_d             = y_q;
      score_d         = score_q;
      combo_d         = combo_q;
      hit_d           = 1'b0;
      miss_d          = 1'b0;
      press_prev_d    = pressed_now;

      unique case (state_q)
         ST_IDLE: begin
            // Address is pinned to 0 so the ROM already presents entry 0 in FETCH
            press_prev_d = '0;
            chart_addr_d = '0;
            frame_cnt_d  = '0;
            if (keycode == KEY_START) state_d = ST_FETCH;
         end

         ST_FETCH: begin
            pending_d       = chart_data;
            pending_valid_d = 1'b1;
            state_d         = ST_RUN;
         end

         ST_RUN: begin
            frame_cnt_d = frame_cnt_q + 13'd1;

            if (refill_q) begin
               pending_d       = chart_data;
               pending_valid_d = 1'b1;
               refill_d        = 1'b0;
            end

            for (int s = 0; s < NUM_SLOTS; s++) begin
               if (active_q[s]) begin
                  y_d[s] = y_q[s] + 10'd1;
                  if (y_d[s] >= MISS_Y) begin
                     active_d[s] = 1'b0;
                     miss_d      = 1'b1;
                  end
               end
            end

            // Per lane, the lowest arrow on screen inside the window is the one hit
            for (int l = 0; l < NUM_LANES; l++) begin
               found  = 1'b0;
               best   = 0;
               best_y = '0;
               if (press_edge[l]) begin
                  for (int s = 0; s < NUM_SLOTS; s++) begin
                     if (active_d[s] && (lane_q[s] == 2'(l)) && (y_d[s] >= HIT_Y) &&
                         (y_d[s] < MISS_Y) && (!found || (y_d[s] > best_y))) begin
                        found  = 1'b1;
                        best   = s;
                        best_y = y_d[s];
                     end
                  end
                  if (found) begin
                     active_d[best] = 1'b0;
                     hit_d          = 1'b1;
                     if (score_d != 16'hFFFF) score_d = score_d + 16'd1;
                     if (combo_d != 8'hFF)    combo_d = combo_d + 8'd1;
                  end
               end
            end

            if (miss_d) combo_d = '0;

            // Launch uses the previous-frame pending state: at most one per two frames
            if (pending_valid_q && free_found &&
                (frame_cnt_d >= pending_q[CH_FRAME_HI:CH_FRAME_LO])) begin
               active_d[free_idx] = 1'b1;
               lane_d[free_idx]   = pending_q[CH_LANE_HI:CH_LANE_LO];
               y_d[free_idx]      = Y_START_V;
               pending_valid_d    = 1'b0;
               if (pending_q[CH_LAST_BIT]) begin
                  chart_done_d = 1'b1;
               end else begin
                  chart_addr_d = chart_addr_q + CHART_AW'(1);
                  refill_d     = 1'b1;
               end
            end

            if (chart_done_d && (active_d == '0)) state_d = ST_DONE;
         end

         ST_DONE: begin
            if (keycode == KEY_RESTART) begin
               state_d         = ST_IDLE;
               frame_cnt_d     = '0;
               chart_addr_d    = '0;
               pending_d       = '0;
               pending_valid_d = 1'b0;
               refill_d        = 1'b0;
               chart_done_d    = 1'b0;
               active_d        = '0;
               lane_d          = '0;
               y_d             = '0;
               score_d         = '0;
               combo_d         = '0;
            end
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q         <= ST_IDLE;
         frame_cnt_q     <= '0;
         chart_addr_q    <= '0;
         pending_q       <= '0;
         pending_valid_q <= 1'b0;
         refill_q        <= 1'b0;
         chart_done_q    <= 1'b0;
         active_q        <= '0;
         lane_q          <= '0;
         y_q             <= '0;
         score_q         <= '0;
         combo_q         <= '0;
         hit_q           <= 1'b0;
         miss_q          <= 1'b0;
         press_prev_q    <= '0;
      end else begin
         state_q         <= state_d;
         frame_cnt_q     <= frame_cnt_d;
         chart_addr_q    <= chart_addr_d;
         pending_q       <= pending_d;
         pending_valid_q <= pending_valid_d;
         refill_q        <= refill_d;
         chart_done_q    <= chart_done_d;
         active_q        <= active_d;
         lane_q          <= lane_d;
         y_q             <= y_d;
         score_q         <= score_d;
         combo_q         <= combo_d;
         hit_q           <= hit_d;
         miss_q          <= miss_d;
         press_prev_q    <= press_prev_d;
      end
   end

   assign chart_addr  = chart_addr_q;
   assign slot_active = active_q;
   assign slot_lane   = lane_q;
   assign slot_y      = y_q;
   assign score       = score_q;
   assign combo       = combo_q;
   assign hit_pulse   = hit_q;
   assign miss_pulse  = miss_q;
   assign game_state  = state_q;

endmodule
`default_nettype wire
